// File: rtl/bocks_pkg.sv
// Shared types and constants for the bocks VRAM writer and its arbiter.
package bocks_pkg;

    localparam int unsigned FB_WORDS_DEFAULT = 307200;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 8;

    // Fill engine FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // One-hot write grant: bit 0 host, bit 1 fill engine.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_HOST = 2'b01,
        GNT_FILL = 2'b10
    } grant_e;

    // Which requester won the most recent grant.
    typedef enum logic {
        LAST_HOST = 1'b0,
        LAST_FILL = 1'b1
    } last_grant_e;

endpackage

// File: rtl/bocks_rr_arb2.sv
// Two-requester round-robin arbiter (host vs fill engine), one-hot grant.
module bocks_rr_arb2
    import bocks_pkg::*;
(
    input  logic   pclk,
    input  logic   reset,
    input  logic   i_req_host,
    input  logic   i_req_fill,
    output grant_e o_grant_c
);

    last_grant_e r_last;

    // Grant selection; on a tie the requester that did not win last time goes.
    always_comb begin
        o_grant_c = GNT_NONE;
        if (reset) begin
            o_grant_c = GNT_NONE;
        end else if (i_req_host && i_req_fill) begin
            if (r_last == LAST_FILL) begin
                o_grant_c = GNT_HOST;
            end else begin
                o_grant_c = GNT_FILL;
            end
        end else if (i_req_host) begin
            o_grant_c = GNT_HOST;
        end else if (i_req_fill) begin
            o_grant_c = GNT_FILL;
        end
    end

    // Remember the last winner; reset value lets the host take the first tie.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_last <= LAST_FILL;
        end else if (o_grant_c == GNT_HOST) begin
            r_last <= LAST_HOST;
        end else if (o_grant_c == GNT_FILL) begin
            r_last <= LAST_FILL;
        end
    end

endmodule

// File: rtl/bocks_vram_writer.sv
// Merges host byte writes and a rectangular-free linear fill engine onto
// the single registered write port of the vga block.
module bocks_vram_writer
    import bocks_pkg::*;
#(
    parameter logic [31:0] FB_BASE  = 32'h0000_0000,
    parameter int unsigned FB_WORDS = FB_WORDS_DEFAULT
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_offset,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              cpu_wr,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_data
);

    localparam logic [ADDR_W-1:0] LP_WORDS = ADDR_W'(FB_WORDS);

    fill_state_e       r_state;
    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_color;
    logic              r_fill_busy;
    logic              r_fill_done;
    logic              r_cpu_wr;
    logic [ADDR_W-1:0] r_cpu_addr;
    logic [DATA_W-1:0] r_cpu_data;

    logic [ADDR_W-1:0] w_room;
    logic [ADDR_W-1:0] w_eff_len;
    logic              w_fill_req;
    logic              w_fill_last;
    grant_e            w_grant;

    // Fill length clipped to the end of the framebuffer.
    assign w_room      = LP_WORDS - fill_offset;
    assign w_eff_len   = (fill_offset >= LP_WORDS) ? '0 :
                         ((fill_len < w_room) ? fill_len : w_room);
    assign w_fill_req  = (r_state == ST_FILL) && (r_idx != r_len);
    assign w_fill_last = ((r_idx + ADDR_W'(1)) == r_len);

    bocks_rr_arb2 u_arb (
        .pclk      (pclk),
        .reset     (reset),
        .i_req_host(host_valid),
        .i_req_fill(w_fill_req),
        .o_grant_c (w_grant)
    );

    assign host_ready = (w_grant == GNT_HOST);

    // Fill FSM: latch parameters on start, step the index on each fill grant.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_offset    <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_color     <= '0;
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (fill_start) begin
                        r_offset    <= fill_offset;
                        r_len       <= w_eff_len;
                        r_color     <= fill_color;
                        r_idx       <= '0;
                        r_state     <= ST_FILL;
                        r_fill_busy <= 1'b1;
                        // Nothing to write: report completion straight away.
                        r_fill_done <= (w_eff_len == '0);
                    end
                end
                ST_FILL: begin
                    if (r_len == '0) begin
                        r_state     <= ST_IDLE;
                        r_fill_busy <= 1'b0;
                    end else if (w_grant == GNT_FILL) begin
                        r_idx <= r_idx + ADDR_W'(1);
                        if (w_fill_last) begin
                            r_state     <= ST_IDLE;
                            r_fill_busy <= 1'b0;
                            r_fill_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered write port; address/data hold while no write is issued.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_cpu_wr   <= 1'b0;
            r_cpu_addr <= '0;
            r_cpu_data <= '0;
        end else begin
            r_cpu_wr <= (w_grant != GNT_NONE);
            if (w_grant == GNT_HOST) begin
                r_cpu_addr <= host_addr;
                r_cpu_data <= host_data;
            end else if (w_grant == GNT_FILL) begin
                r_cpu_addr <= FB_BASE + r_offset + r_idx;
                r_cpu_data <= r_color;
            end
        end
    end

    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;
    assign cpu_wr    = r_cpu_wr;
    assign cpu_addr  = r_cpu_addr;
    assign cpu_data  = r_cpu_data;

endmodule

// File: doc/bocks_vram_writer.md
BOCKS_VRAM_WRITER -- requirements
Module: bocks_vram_writer

Interface
REQ-001 The module SHALL have parameter FB_BASE, default 32'h00000000, byte address of the first framebuffer location.
REQ-002 The module SHALL have parameter FB_WORDS, default 307200, number of writable framebuffer locations (640x480).
REQ-003 The module SHALL have port pclk  input  1  the single clock, shared with the vga block's cpu_clk.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of pclk.
REQ-005 The module SHALL have port host_valid  input  1  host write request pending.
REQ-006 The module SHALL have port host_ready  output  1  host write accepted this cycle.
REQ-007 The module SHALL have port host_addr  input  32  host target address.
REQ-008 The module SHALL have port host_data  input  8  host write data.
REQ-009 The module SHALL have port fill_start  input  1  single-cycle fill command.
REQ-010 The module SHALL have port fill_offset  input  32  first fill location, as an index relative to FB_BASE.
REQ-011 The module SHALL have port fill_len  input  32  number of locations to fill.
REQ-012 The module SHALL have port fill_color  input  8  fill data value.
REQ-013 The module SHALL have port fill_busy  output  1  fill in progress.
REQ-014 The module SHALL have port fill_done  output  1  single-cycle pulse when a fill completes.
REQ-015 The module SHALL have port cpu_wr  output  1  write strobe to the vga block.
REQ-016 The module SHALL have port cpu_addr  output  32  write address to the vga block.
REQ-017 The module SHALL have port cpu_data  output  8  write data to the vga block.

Function
REQ-018 The module SHALL run an FSM with two states: IDLE and FILL.
REQ-019 In IDLE, fill_start SHALL latch fill_offset, fill_len and fill_color and move the FSM to FILL; fill_busy SHALL rise on the next cycle.
REQ-020 In FILL, fill_start SHALL be ignored and none of the latched fill parameters SHALL change.
REQ-021 The effective fill length SHALL be min(fill_len, FB_WORDS - fill_offset), or 0 when fill_offset >= FB_WORDS.
REQ-022 An effective length of 0 SHALL produce no writes: fill_done pulses and the FSM returns to IDLE one cycle after fill_start.
REQ-023 The fill SHALL issue writes in order to FB_BASE+fill_offset, FB_BASE+fill_offset+1, and so on, one per granted cycle, using a 32-bit index counter.
REQ-024 After the grant of the final fill write, fill_done SHALL pulse for exactly one cycle, concurrent with that write's cpu_wr, and the FSM SHALL return to IDLE.
REQ-025 At most one write SHALL be granted per cycle, to either the host or the fill engine.
REQ-026 Host-only contention: host_ready = host_valid.
REQ-027 Fill-only contention: the fill engine SHALL be granted every cycle.
REQ-028 When the host and the fill engine both request, grants SHALL alternate round-robin using a last_grant flag; host wins the first tie after reset.
REQ-029 host_ready SHALL be combinational and SHALL depend only on host_valid and the arbitration state.
REQ-030 A host transfer SHALL occur when host_valid and host_ready are both high.
REQ-031 The host SHALL hold host_addr and host_data stable while host_valid is high.
REQ-032 cpu_wr, cpu_addr and cpu_data SHALL be registered, with cpu_wr asserted the cycle after a grant (latency 1).
REQ-033 cpu_wr SHALL be low in any cycle following a cycle with no grant.
REQ-034 cpu_addr and cpu_data SHALL hold their last values while cpu_wr is low.
REQ-035 host_addr SHALL pass to cpu_addr unmodified, with no range check.
REQ-036 fill_start and host_valid arriving in the same IDLE cycle: the host SHALL be granted that cycle, and fill writes start from the next cycle under round-robin.

Reset
REQ-037 On reset, the FSM SHALL go to IDLE, and cpu_wr, fill_busy, fill_done and host_ready SHALL be 0.
REQ-038 On reset, cpu_addr SHALL be 0, cpu_data SHALL be 0, last_grant SHALL be FILL (so the host wins the next tie), and the index counter SHALL be 0.
REQ-039 Reset during FILL SHALL abort the fill with no fill_done pulse, and no cpu_wr SHALL be issued in the cycle after reset.

Structure
REQ-040 The FSM state encoding, the grant encoding, and the FB_WORDS default SHALL live in a shared package, bocks_pkg.
REQ-041 The arbiter SHALL be a sub-module, bocks_rr_arb2 (two-requester round-robin, one-hot grant).
REQ-042 The FSM and fill counter SHALL remain in bocks_vram_writer.
REQ-043 bocks_top SHALL instantiate bocks_vram_writer and drive the vga block's cpu_* inputs from it.

Verification
REQ-044 Scenario: fill_start with offset 0, len 4, color 8'hAA -> cpu_wr high for 4 consecutive cycles at addresses 0..3 with data AA; fill_done pulses with the 4th write; fill_busy is then low.
REQ-045 Scenario: host_valid held for 3 writes while a fill of len 4 runs -> the sequence alternates H,F,H,F,H,F,F; 7 writes in total, each address written exactly once.
REQ-046 Scenario: fill_len 0, and separately fill_offset = FB_WORDS-2 with len 10 -> the first gives no writes and fill_done one cycle after start; the second gives exactly 2 writes (FB_WORDS-2 and FB_WORDS-1).
REQ-047 Scenario: fill_start pulsed again mid-fill with color 8'h55 -> ignored; all writes carry the original color.
REQ-048 Scenario: reset asserted after the 2nd write of a len-8 fill -> no further cpu_wr, no fill_done, all outputs at reset values; a new fill started afterwards begins at its own offset.
REQ-049 Scenario: host_valid and fill_start in the same idle cycle -> host write appears first at latency 1, followed by alternating grants.
